lane_pipe_reg: RTL and testbench

LANE_PIPE_REG -- requirements
Module: lane_pipe_reg

---
 rtl/lane_pipe_pkg.sv | 17 +
 rtl/lane_pipe_stage.sv | 42 ++++
 rtl/lane_pipe_reg.sv | 91 +++++++++
 tb/tb_lane_pipe_reg.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_pipe_pkg.sv
// Shared constants and helpers for the multi-lane elastic pipeline register.
package lane_pipe_pkg;

  // Legal parameter ranges for lane_pipe_reg.
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int LANES_MIN = 1;
  localparam int LANES_MAX = 32;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 16;

  // Bits needed to count 0..depth valid stages in one lane.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lane_pipe_stage.sv
// One elastic pipeline stage: a data register plus a valid bit.
// The load enable (i_ready) is this stage's ready, computed by the lane.
// The data register is forced to zero whenever the stage is empty, so the
// last stage can drive out_data straight from its register.
module lane_pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_ready,
  input  logic             i_up_valid,
  input  logic [WIDTH-1:0] i_up_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Stage register: clear on reset/flush, load from upstream when ready, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data register is reset too, not only the valid bit, because
    // out_data must read zero whenever nothing valid sits in the stage.
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_ready) begin
      // NOTE: non-blocking assignments let every stage sample the old value
      // of its neighbour on the same edge, which is what makes this a pipeline.
      r_valid <= i_up_valid;
      r_data  <= i_up_valid ? i_up_data : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/lane_pipe_reg.sv
// LANES independent elastic pipelines, each DEPTH stages deep, with a
// combinational ready chain (no bubbles), per-lane flush and a registered
// per-lane occupancy count.
module lane_pipe_reg
  import lane_pipe_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int LANES = 4,
  parameter  int DEPTH = 2,
  localparam int CW    = occ_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES-1:0]       in_valid,
  output logic [LANES-1:0]       in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic [LANES-1:0]       flush,
  output logic [LANES*CW-1:0]    occupancy
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DEPTH-1:0]       w_valid;
    logic [DEPTH:0]         w_ready;
    logic [DEPTH*WIDTH-1:0] w_data;
    logic                   w_accept;
    logic                   w_emit;
    logic [CW-1:0]          r_occ;

    // Ready chain: a stage is ready when empty or when the stage after it is ready.
    always_comb begin
      // NOTE: every bit of w_ready is written on every evaluation, so no latch
      // can be inferred even though the loop builds the chain bit by bit.
      w_ready[DEPTH] = out_ready[l];
      for (int k = DEPTH - 1; k >= 0; k--) begin
        w_ready[k] = ~w_valid[k] | w_ready[k+1];
      end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             w_up_valid;
      logic [WIDTH-1:0] w_up_data;

      if (k == 0) begin : g_head
        assign w_up_valid = in_valid[l];
        assign w_up_data  = in_data[l*WIDTH +: WIDTH];
      end else begin : g_body
        assign w_up_valid = w_valid[k-1];
        assign w_up_data  = w_data[(k-1)*WIDTH +: WIDTH];
      end

      lane_pipe_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush[l]),
        .i_ready    (w_ready[k]),
        .i_up_valid (w_up_valid),
        .i_up_data  (w_up_data),
        .o_valid    (w_valid[k]),
        .o_data     (w_data[k*WIDTH +: WIDTH])
      );
    end

    // A flushing lane refuses new words; the stage-0 clear already drops them.
    assign in_ready[l] = w_ready[0] & ~flush[l];
    assign w_accept    = in_valid[l] & in_ready[l];
    assign w_emit      = w_valid[DEPTH-1] & out_ready[l];

    // Occupancy: +1 on accept only, -1 on emit only, zero on flush.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_occ <= '0;
      end else if (flush[l]) begin
        r_occ <= '0;
      end else if (w_accept && !w_emit) begin
        r_occ <= r_occ + CW'(1);
      end else if (!w_accept && w_emit) begin
        r_occ <= r_occ - CW'(1);
      end
    end

    assign out_valid[l]                = w_valid[DEPTH-1];
    assign out_data[l*WIDTH +: WIDTH]  = w_data[(DEPTH-1)*WIDTH +: WIDTH];
    assign occupancy[l*CW +: CW]       = r_occ;
  end

endmodule

// File: tb/tb_lane_pipe_reg.sv
// Bench for lane_pipe_reg: directed cases on an 8-bit/4-lane/3-deep instance
// plus a randomized run on a 1-bit/4-lane/1-deep instance. A negedge monitor
// keeps a per-lane expected-word queue and checks every output transfer.
module tb_lane_pipe_reg;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: WIDTH=8, LANES=4, DEPTH=3
  logic [3:0]  a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [31:0] a_in_data, a_out_data;
  logic [7:0]  a_occ;

  // Instance B: WIDTH=1, LANES=4, DEPTH=1
  logic [3:0]  b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [3:0]  b_in_data, b_out_data, b_occ;

  logic [7:0] qa [4][$];
  logic       qb [4][$];

  int n_pass  = 0;
  int n_total = 0;

  lane_pipe_reg #(.WIDTH(8), .LANES(4), .DEPTH(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(a_flush), .occupancy(a_occ)
  );

  lane_pipe_reg #(.WIDTH(1), .LANES(4), .DEPTH(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush), .occupancy(b_occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic flag_extra(input string name);
    n_total++;
    $display("FAIL %s: output word delivered while none was expected", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] a_od(input int l);
    return a_out_data[l*8 +: 8];
  endfunction

  function automatic logic [1:0] a_oc(input int l);
    return a_occ[l*2 +: 2];
  endfunction

  // Scoreboard monitor: pop on output transfer, drop on flush, push on accept.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int l = 0; l < 4; l++) begin
          if (a_out_valid[l] && a_out_ready[l]) begin
            if (qa[l].size() == 0) flag_extra($sformatf("a_lane%0d_extra", l));
            else check($sformatf("a_lane%0d_order", l), 64'(a_out_data[l*8 +: 8]),
                       64'(qa[l].pop_front()));
          end
          if (a_flush[l]) qa[l].delete();
          if (a_in_valid[l] && a_in_ready[l]) qa[l].push_back(a_in_data[l*8 +: 8]);

          if (b_out_valid[l] && b_out_ready[l]) begin
            if (qb[l].size() == 0) flag_extra($sformatf("b_lane%0d_extra", l));
            else check($sformatf("b_lane%0d_order", l), 64'(b_out_data[l]),
                       64'(qb[l].pop_front()));
          end
          if (b_flush[l]) qb[l].delete();
          if (b_in_valid[l] && b_in_ready[l]) qb[l].push_back(b_in_data[l]);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    a_in_valid  = '0; a_in_data = '0; a_flush = '0; a_out_ready = 4'hF;
    b_in_valid  = '0; b_in_data = '0; b_flush = '0; b_out_ready = 4'hF;

    // Reset state
    #3;
    check("rst_a_out_valid", 64'(a_out_valid), 0);
    check("rst_a_out_data",  64'(a_out_data),  0);
    check("rst_a_occ",       64'(a_occ),       0);
    check("rst_a_in_ready",  64'(a_in_ready),  'hF);
    check("rst_b_out_valid", 64'(b_out_valid), 0);
    check("rst_b_in_ready",  64'(b_in_ready),  'hF);
    #9 rst_n = 1'b1;
    tick();

    // Back-to-back words on lane 0, out_ready high: 2-cycle visible latency
    a_in_valid[0] = 1'b1; a_in_data[7:0] = 8'h11; tick();
    check("bb_occ_e1", 64'(a_oc(0)), 1);
    check("bb_ov_e1",  64'(a_out_valid[0]), 0);
    a_in_data[7:0] = 8'h22; tick();
    check("bb_occ_e2", 64'(a_oc(0)), 2);
    check("bb_ov_e2",  64'(a_out_valid[0]), 0);
    a_in_data[7:0] = 8'h33; tick();
    a_in_valid[0] = 1'b0;
    check("bb_ov_e3",  64'(a_out_valid[0]), 1);
    check("bb_od_e3",  64'(a_od(0)), 'h11);
    check("bb_occ_e3", 64'(a_oc(0)), 3);
    tick();
    check("bb_od_e4",  64'(a_od(0)), 'h22);
    check("bb_occ_e4", 64'(a_oc(0)), 2);
    tick();
    check("bb_od_e5",  64'(a_od(0)), 'h33);
    check("bb_occ_e5", 64'(a_oc(0)), 1);
    tick();
    check("bb_ov_e6",  64'(a_out_valid[0]), 0);
    check("bb_od_e6",  64'(a_od(0)), 0);
    check("bb_occ_e6", 64'(a_oc(0)), 0);

    // Backpressure on lane 2: three words fill the lane, the fourth waits
    a_out_ready[2] = 1'b0;
    a_in_valid[2]  = 1'b1;
    a_in_data[23:16] = 8'hA1; tick();
    a_in_data[23:16] = 8'hA2; tick();
    a_in_data[23:16] = 8'hA3; tick();
    a_in_data[23:16] = 8'hA4;
    check("bp_in_ready",  64'(a_in_ready), 'hB);
    check("bp_occ",       64'(a_occ), 'h30);
    check("bp_od2",       64'(a_od(2)), 'hA1);
    tick();
    check("bp_hold_occ",  64'(a_occ), 'h30);
    check("bp_hold_rdy",  64'(a_in_ready), 'hB);
    check("bp_hold_od2",  64'(a_od(2)), 'hA1);
    a_out_ready[2] = 1'b1; #1;
    check("bp_full_pass_rdy", 64'(a_in_ready[2]), 1);
    tick();
    a_in_valid[2] = 1'b0;
    check("bp_rel_od_a2",  64'(a_od(2)), 'hA2);
    check("bp_rel_occ_a2", 64'(a_oc(2)), 3);
    tick();
    check("bp_rel_od_a3",  64'(a_od(2)), 'hA3);
    check("bp_rel_occ_a3", 64'(a_oc(2)), 2);
    tick();
    check("bp_rel_od_a4",  64'(a_od(2)), 'hA4);
    check("bp_rel_occ_a4", 64'(a_oc(2)), 1);
    tick();
    check("bp_drained_ov", 64'(a_out_valid[2]), 0);
    check("bp_drained_occ", 64'(a_occ), 0);

    // Full lane 1 streams at full rate: accept and emit on the same edge
    a_out_ready[1] = 1'b0;
    a_in_valid[1]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_data[15:8] = 8'hB0 + 8'(i); tick();
    end
    check("st_full_rdy", 64'(a_in_ready[1]), 0);
    check("st_full_occ", 64'(a_oc(1)), 3);
    a_out_ready[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in_data[15:8] = 8'hB3 + 8'(i); #1;
      check($sformatf("st_rdy_c%0d", i), 64'(a_in_ready[1]), 1);
      if (i == 0) check("st_first_out", 64'(a_od(1)), 'hB0);
      tick();
      check($sformatf("st_occ_c%0d", i), 64'(a_oc(1)), 3);
    end
    a_in_valid[1] = 1'b0;
    check("st_after_od", 64'(a_od(1)), 'hBA);
    tick(); tick(); tick();
    check("st_drained_occ", 64'(a_oc(1)), 0);

    // Flush lane 3 holding two words while it offers a third
    a_out_ready[3] = 1'b0; a_out_ready[0] = 1'b0;
    a_in_valid[3]  = 1'b1; a_in_data[31:24] = 8'hC1;
    a_in_valid[0]  = 1'b1; a_in_data[7:0]   = 8'hD1;
    tick();
    a_in_valid[0] = 1'b0;
    a_in_data[31:24] = 8'hC2; tick();
    a_flush[3] = 1'b1; a_in_data[31:24] = 8'hC3; #1;
    check("fl_pre_occ3",  64'(a_oc(3)), 2);
    check("fl_in_ready3", 64'(a_in_ready[3]), 0);
    tick();
    a_flush[3] = 1'b0; a_in_valid[3] = 1'b0;
    check("fl_occ3",  64'(a_oc(3)), 0);
    check("fl_ov3",   64'(a_out_valid[3]), 0);
    check("fl_od3",   64'(a_od(3)), 0);
    check("fl_ov0",   64'(a_out_valid[0]), 1);
    check("fl_od0",   64'(a_od(0)), 'hD1);
    check("fl_occ0",  64'(a_oc(0)), 1);
    tick();
    check("fl_no_accept_ov3",  64'(a_out_valid[3]), 0);
    check("fl_no_accept_occ3", 64'(a_oc(3)), 0);
    a_out_ready = 4'hF; tick();
    check("fl_drained_occ", 64'(a_occ), 0);

    // Asynchronous reset with every lane full
    a_out_ready = 4'h0; a_in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      a_in_data = 32'h44332211 + 32'h01010101 * 32'(i); tick();
    end
    a_in_valid = 4'h0;
    check("ar_full_occ", 64'(a_occ), 'hFF);
    check("ar_full_ov",  64'(a_out_valid), 'hF);
    check("ar_full_od",  64'(a_out_data), 'h44332211);
    #1 rst_n = 1'b0;
    #1;
    check("ar_ov",  64'(a_out_valid), 0);
    check("ar_od",  64'(a_out_data), 0);
    check("ar_occ", 64'(a_occ), 0);
    check("ar_rdy", 64'(a_in_ready), 'hF);
    for (int l = 0; l < 4; l++) begin
      qa[l].delete();
      qb[l].delete();
    end
    #1 rst_n = 1'b1;
    a_out_ready = 4'hF;
    tick();
    a_in_valid[0] = 1'b1; a_in_data[7:0] = 8'hE5; tick();
    a_in_valid[0] = 1'b0;
    check("pr_ov_n0", 64'(a_out_valid[0]), 0);
    tick();
    check("pr_ov_n1", 64'(a_out_valid[0]), 0);
    tick();
    check("pr_ov_n2", 64'(a_out_valid[0]), 1);
    check("pr_od_n2", 64'(a_od(0)), 'hE5);
    tick();
    check("pr_ov_n3", 64'(a_out_valid[0]), 0);

    // Randomized valid/ready on the 1-bit, 1-deep instance
    for (int c = 0; c < 400; c++) begin
      b_in_valid  = 4'($urandom);
      b_out_ready = 4'($urandom);
      b_in_data   = 4'($urandom);
      tick();
    end
    b_in_valid = 4'h0; b_out_ready = 4'hF;
    tick(); tick();
    check("rnd_b_occ", 64'(b_occ), 0);
    check("rnd_b_ov",  64'(b_out_valid), 0);
    for (int l = 0; l < 4; l++) begin
      check($sformatf("rnd_b_q%0d_empty", l), 64'(qb[l].size()), 0);
      check($sformatf("a_q%0d_empty", l), 64'(qa[l].size()), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
